// File: rtl/audio_clk_pkg.sv
// audio_clk_pkg: shared definitions for the audio clock generator.
//   - default parameter values (100 MHz clk -> 12.5 MHz mclk, 3.125 MHz sclk,
//     2 x 32-bit slots, 2048 clk cycles per frame)
//   - FSM state type
//   - counter width helper
package audio_clk_pkg;

   localparam int unsigned DEF_MCLK_DIV   = 8;
   localparam int unsigned DEF_SCLK_RATIO = 4;
   localparam int unsigned DEF_SLOT_BITS  = 32;
   localparam int unsigned DEF_SLOTS      = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } clkgen_state_e;

   // Bits needed to hold 0..n-1; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/audio_clkgen_phase_counter.sv
// phase_counter: modulo-N up-counter with synchronous clear and count enable.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       force the count to 0 on the next edge (wins over en_i)
//   en_i        advance the count on the next edge
//   cnt_d_o     value the count takes on the next edge
//   wrap_o      count is at N-1 and is advancing this cycle
// The next value is exported rather than the current one so the parent can
// register its decoded outputs on the same edge as the count itself.
module phase_counter #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_d_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign wrap_o = en_i && !clr_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_d_o = cnt_d;

endmodule

// File: rtl/audio_clkgen.sv
// audio_clkgen: derives phase-locked mclk, sclk and lrck from clk, plus
// clk-domain position strobes for the sample serializer.
//
// state | meaning
// IDLE  | counters held at 0, every output 0, waiting for en
// RUN   | counters free-running, frames emitted back to back
// DRAIN | en dropped; finish the current frame, then stop (or resume on en)
//
// Ports:
//   clk          system clock (100 MHz)
//   rst          asynchronous active-low reset
//   en           run request
//   dsp_mode     DSP/TDM frame-sync select, sampled in IDLE
//                (present only with AUDIO_CLKGEN_DSP_MODE_EN defined)
//   running      generator active (RUN or DRAIN)
//   mclk, sclk   master / bit clock, 50 % duty
//   lrck         frame clock (50 % I2S framing, or one-sclk pulse in DSP mode)
//   frame_start  one-clk pulse on the first cycle of a frame
//   sclk_fall    one-clk pulse on the cycle where sclk goes 1->0
//   slot_idx     current slot
//   bit_idx      current bit within slot, 0 = MSB
//
// Optional feature macro: AUDIO_CLKGEN_DSP_MODE_EN.
module audio_clkgen
   import audio_clk_pkg::*;
#(
   parameter int unsigned MCLK_DIV   = DEF_MCLK_DIV,
   parameter int unsigned SCLK_RATIO = DEF_SCLK_RATIO,
   parameter int unsigned SLOT_BITS  = DEF_SLOT_BITS,
   parameter int unsigned SLOTS      = DEF_SLOTS
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
`ifdef AUDIO_CLKGEN_DSP_MODE_EN
   input  logic                            dsp_mode,
`endif
   output logic                            running,
   output logic                            mclk,
   output logic                            sclk,
   output logic                            lrck,
   output logic                            frame_start,
   output logic                            sclk_fall,
   output logic [cnt_width(SLOTS)-1:0]     slot_idx,
   output logic [cnt_width(SLOT_BITS)-1:0] bit_idx
);

   localparam int unsigned P  = MCLK_DIV * SCLK_RATIO;
   localparam int unsigned PW = cnt_width(P);
   localparam int unsigned BW = cnt_width(SLOT_BITS);
   localparam int unsigned SW = cnt_width(SLOTS);

   localparam logic [PW-1:0] P_HALF = PW'(P / 2);
   localparam logic [SW-1:0] S_HALF = SW'(SLOTS / 2);

   if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_mclk_div
      $fatal(1, "audio_clkgen: MCLK_DIV must be even and >= 2");
   end
   if (SCLK_RATIO < 1) begin : g_bad_sclk_ratio
      $fatal(1, "audio_clkgen: SCLK_RATIO must be >= 1");
   end
   if (SLOT_BITS < 2) begin : g_bad_slot_bits
      $fatal(1, "audio_clkgen: SLOT_BITS must be >= 2");
   end
   if (SLOTS < 2 || (SLOTS % 2) != 0) begin : g_bad_slots
      $fatal(1, "audio_clkgen: SLOTS must be even and >= 2");
   end

   clkgen_state_e state_q;
   clkgen_state_e state_d;

   logic          cnt_clr;
   logic          cnt_en;
   logic [PW-1:0] p_d;
   logic [BW-1:0] bit_d;
   logic [SW-1:0] slot_d;
   logic          p_wrap;
   logic          bit_wrap;
   logic          frame_end;
   logic [31:0]   m_d;

   logic          running_d;
   logic          mclk_d;
   logic          sclk_d;
   logic          lrck_d;
   logic          frame_start_d;
   logic          sclk_fall_d;
   logic [SW-1:0] slot_out_d;
   logic [BW-1:0] bit_out_d;
   logic          dsp_sel;

   // Counters advance on the same edge that enters RUN from IDLE only after
   // that edge: the IDLE->RUN edge leaves them at 0, which is the first
   // frame cycle.
   assign cnt_clr = (state_q == ST_IDLE);
   assign cnt_en  = (state_q != ST_IDLE);

   phase_counter #(.N(P), .W(PW)) u_p_cnt (
      .clk     (clk),
      .rst_n   (rst),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .cnt_d_o (p_d),
      .wrap_o  (p_wrap)
   );

   phase_counter #(.N(SLOT_BITS), .W(BW)) u_bit_cnt (
      .clk     (clk),
      .rst_n   (rst),
      .clr_i   (cnt_clr),
      .en_i    (p_wrap),
      .cnt_d_o (bit_d),
      .wrap_o  (bit_wrap)
   );

   phase_counter #(.N(SLOTS), .W(SW)) u_slot_cnt (
      .clk     (clk),
      .rst_n   (rst),
      .clr_i   (cnt_clr),
      .en_i    (bit_wrap),
      .cnt_d_o (slot_d),
      .wrap_o  (frame_end)
   );

   // mclk phase; P is a multiple of MCLK_DIV so this stays locked to sclk.
   assign m_d = 32'(p_d) % MCLK_DIV;

`ifdef AUDIO_CLKGEN_DSP_MODE_EN
   logic dsp_q;

   // The first cycle of a run is decoded while still in IDLE, so it takes
   // the live input; afterwards the captured value is used.
   assign dsp_sel = (state_q == ST_IDLE) ? dsp_mode : dsp_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dsp_q <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         dsp_q <= dsp_mode;
      end
   end
`else
   assign dsp_sel = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (en) state_d = ST_RUN;
         ST_RUN:   if (!en) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (en) begin
               state_d = ST_RUN;
            end else if (frame_end) begin
               state_d = ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      running_d     = (state_d != ST_IDLE);
      mclk_d        = 1'b0;
      sclk_d        = 1'b0;
      lrck_d        = 1'b0;
      frame_start_d = 1'b0;
      sclk_fall_d   = 1'b0;
      slot_out_d    = '0;
      bit_out_d     = '0;
      if (running_d) begin
         mclk_d        = (m_d >= (MCLK_DIV / 2));
         sclk_d        = (p_d >= P_HALF);
         sclk_fall_d   = (p_d == '0);
         frame_start_d = (p_d == '0) && (bit_d == '0) && (slot_d == '0);
         lrck_d        = dsp_sel ? ((slot_d == '0) && (bit_d == '0))
                                 : (slot_d >= S_HALF);
         slot_out_d    = slot_d;
         bit_out_d     = bit_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         running     <= 1'b0;
         mclk        <= 1'b0;
         sclk        <= 1'b0;
         lrck        <= 1'b0;
         frame_start <= 1'b0;
         sclk_fall   <= 1'b0;
         slot_idx    <= '0;
         bit_idx     <= '0;
      end else begin
         state_q     <= state_d;
         running     <= running_d;
         mclk        <= mclk_d;
         sclk        <= sclk_d;
         lrck        <= lrck_d;
         frame_start <= frame_start_d;
         sclk_fall   <= sclk_fall_d;
         slot_idx    <= slot_out_d;
         bit_idx     <= bit_out_d;
      end
   end

endmodule

// File: doc/audio_clkgen.md
# audio_clkgen

- Parametrised audio clock generator for the synthesiser's DAC path.
- From the 100 MHz system clock it derives phase-locked master clock (mclk), bit clock (sclk) and frame clock (lrck).
- Supports any even slot count (stereo I2S or TDM) and provides clean start/stop at frame boundaries.
- Drives frame/slot/bit position strobes so the sample serializer runs in the `clk` domain without sampling generated clocks.

## Interface
- `MCLK_DIV`, 8: `clk` cycles per mclk period; even, ≥2 (100 MHz → 12.5 MHz).
- `SCLK_RATIO`, 4: mclk periods per sclk period; ≥1.
- `SLOT_BITS`, 32: sclk periods per slot; ≥2.
- `SLOTS`, 2: slots per frame; even, ≥2.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run request.
- `running`  out  1  generator active (RUN or DRAIN).
- `mclk`  out  1  master clock, 50 % duty.
- `sclk`  out  1  bit clock, 50 % duty.
- `lrck`  out  1  frame clock.
- `frame_start`  out  1  one-`clk` pulse, first cycle of a frame.
- `sclk_fall`  out  1  one-`clk` pulse, cycle in which sclk goes 1→0.
- `slot_idx`  out  `max(1,$clog2(SLOTS))`  current slot.
- `bit_idx`  out  `$clog2(SLOT_BITS)`  current bit within slot, 0 = MSB.

## Operation
- Derived constant: P = MCLK_DIV*SCLK_RATIO (`clk` cycles per sclk). Frame length = P*SLOT_BITS*SLOTS.
- Phase counter p runs 0..P-1; mclk phase m = p mod MCLK_DIV.
- All outputs are registered.
  - mclk = (m ≥ MCLK_DIV/2).
  - sclk = (p ≥ P/2).
- bit_idx advances when p wraps from P-1 to 0.
- slot_idx advances when bit_idx wraps SLOT_BITS-1→0; it wraps SLOTS-1→0 at frame end.
- lrck (I2S/left-justified) = 0 for slot_idx < SLOTS/2, 1 otherwise. The one-bit I2S delay belongs to the serializer.
- frame_start = 1 when p=0, bit_idx=0, slot_idx=0 and running.
- sclk_fall = 1 on every cycle with p=0 while running, including the first cycle of a run.
- FSM:
  - IDLE: counters held at 0; all outputs 0. `en`=1 → RUN.
  - RUN: counters free-run. `en`=0 → DRAIN.
  - DRAIN: counters free-run until the last cycle of the frame (p=P-1, bit=SLOT_BITS-1, slot=SLOTS-1).
    - If `en`=1 when that cycle is reached → RUN; counting continues without a gap.
    - Otherwise → IDLE.
  - `en` re-asserted in DRAIN before frame end → RUN, with no restart.
- No truncated frames are ever emitted. mclk stops low, together with sclk.
- Reset asserted at any time: FSM = IDLE and every output = 0 immediately. Operation resumes only after `rst` is released and `en` is sampled high.

## Timing
- `en` sampled 1 in IDLE at edge N:
  - running=1, frame_start=1, sclk_fall=1 and p=0 from edge N+1.
  - mclk/sclk first rise at p=MCLK_DIV/2 and p=P/2 respectively.
- Latency from any counter state to its outputs: 0 cycles. Outputs are decoded from the registered next state, so output registers and counters update on the same edge.
- Stop: running falls on the edge after the last frame cycle. lrck, sclk and mclk are 0 on that same edge.
- Defaults give mclk 12.5 MHz, sclk 3.125 MHz, frame 2048 `clk` cycles (48.828 kHz).

## Configuration
- Macro: `AUDIO_CLKGEN_DSP_MODE_EN`.
- Defined: adds input `dsp_mode` (1 bit).
  - When 1, lrck = 1 only while slot_idx=0 and bit_idx=0 (one-sclk frame sync pulse, DSP/TDM format).
  - `dsp_mode` is sampled only in IDLE and held for the whole run.
- Undefined: no port; lrck always uses the 50 % I2S framing.

## Structure
- Package `audio_clk_pkg` holds:
  - default parameter constants;
  - the FSM state typedef (IDLE, RUN, DRAIN);
  - width helper localparams.
- Parameter legality is checked at elaboration; an illegal set (odd MCLK_DIV, odd SLOTS) is a fatal error.
- Sub-module `phase_counter`: generic modulo-N counter with clear, enable and wrap output. It is instantiated for the bit and slot counters. The sclk phase p uses the same module with N=P.

## Test plan
- Defaults, en=1 after reset → frame_start at cycle 1 and every 2048 cycles; mclk period 8; sclk period 32; lrck toggles every 1024 cycles.
- en dropped at cycle 1500 → counting continues; running falls at cycle 2049; no frame_start at 2049; all outputs 0.
- en dropped at cycle 1500, re-raised at 1800 → no gap; frame_start at cycle 2049.
- SLOTS=8, SLOT_BITS=16, MCLK_DIV=2, SCLK_RATIO=1:
  - slot_idx steps 0..7 every 32 cycles;
  - lrck high for slots 4..7;
  - frame 256 cycles.
- `rst` asserted asynchronously mid-frame (between edges) → all outputs 0 before the next edge; after release with en=1, frame_start one cycle later.
- With `AUDIO_CLKGEN_DSP_MODE_EN` and dsp_mode=1 at defaults → lrck high for 32 cycles at frame start, low for the remaining 2016.
